// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: instruction memory request/response and decode handshake,
// plus the redirect input from execute.
interface instr_fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;
    logic             if_valid;
    logic [WIDTH-1:0] if_instr;
    logic [WIDTH-1:0] if_pc;
    logic             if_ready;

    modport master (
        input  redirect, redirect_pc, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, a small
// {pc, instr} FIFO toward decode, and redirect-driven flush.
module instr_fetch_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    instr_fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] pc_mem_q [DEPTH];
    logic [WIDTH-1:0] pc_mem_d [DEPTH];
    logic [WIDTH-1:0] ins_mem_q [DEPTH];
    logic [WIDTH-1:0] ins_mem_d [DEPTH];
    logic             issue, push, pop;

    always_comb begin
        issue = (state_q == IDLE) && !bus.redirect
              && (count_q < CW'(DEPTH)) && !rst;
        push  = (state_q == WAIT) && bus.imem_rvalid && !bus.redirect;
        pop   = (count_q != '0) && bus.if_ready && !bus.redirect;
    end

    // A redirect with no response yet leaves the old request in flight,
    // so its eventual response must be swallowed in DROP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (issue) state_d = WAIT;
            WAIT: begin
                if (bus.imem_rvalid)  state_d = IDLE;
                else if (bus.redirect) state_d = DROP;
            end
            DROP: if (bus.imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pc_mem_d   = pc_mem_q;
        ins_mem_d  = ins_mem_q;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[WIDTH-1:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + WIDTH'(4);
                req_pc_d   = fetch_pc_q;
            end
            if (push) begin
                pc_mem_d[wr_ptr_q]  = req_pc_q;
                ins_mem_d[wr_ptr_q] = bus.imem_rdata;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            req_pc_q   <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pc_mem_q   <= pc_mem_d;
            ins_mem_q  <= ins_mem_d;
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.if_valid  = (count_q != '0);
    assign bus.if_instr  = ins_mem_q[rd_ptr_q];
    assign bus.if_pc     = pc_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table for the steady-state
// fetch stream plus hand sequences for stall, redirect, wrap and reset.
module tb_instr_fetch_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    instr_fetch_unit_if #(.WIDTH(32)) bus ();

    instr_fetch_unit #(.WIDTH(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] ins;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic ex(input string nm, input logic req,
                      input logic [31:0] addr, input logic vld,
                      input logic [31:0] pc, input logic [31:0] ins);
        chk({nm, " imem_req"}, 32'(bus.imem_req), 32'(req));
        if (req) chk({nm, " imem_addr"}, bus.imem_addr, addr);
        chk({nm, " if_valid"}, 32'(bus.if_valid), 32'(vld));
        if (vld) begin
            chk({nm, " if_pc"}, bus.if_pc, pc);
            chk({nm, " if_instr"}, bus.if_instr, ins);
        end
    endtask

    task automatic set_in(input logic rv, input logic [31:0] rd,
                          input logic rdy, input logic rdir,
                          input logic [31:0] rpc);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        bus.if_ready    = rdy;
        bus.redirect    = rdir;
        bus.redirect_pc = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst imem_addr", bus.imem_addr, 32'd0);
        chk("rst if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst if_pc", bus.if_pc, 32'd0);
        chk("rst if_instr", bus.if_instr, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;

        tbl[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 32'h00000013, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h00000013};
        tbl[3] = '{1'b1, 32'h00100093, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4, 32'h00100093};
        tbl[5] = '{1'b1, 32'h00200113, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h8, 32'h00200113};

        // Zero-wait memory stream
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(tbl[i].rv, tbl[i].rd, tbl[i].rdy, 1'b0, 32'h0);
            ex($sformatf("stream%0d", i), tbl[i].req, tbl[i].addr,
               tbl[i].vld, tbl[i].pc, tbl[i].ins);
            tick();
        end

        // Decode stalled: FIFO fills to 4, fetch stops, then drains
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(0, 0, 0, 0, 0);
            ex($sformatf("fill%0d req", k), 1, 32'(4 * k), k != 0,
               32'h0, 32'h100);
            tick();
            set_in(1, 32'(32'h100 + k), 0, 0, 0);
            ex($sformatf("fill%0d rsp", k), 0, 0, k != 0, 32'h0, 32'h100);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            set_in(0, 0, 0, 0, 0);
            ex($sformatf("full%0d", j), 0, 0, 1, 32'h0, 32'h100);
            tick();
        end
        set_in(0, 0, 1, 0, 0);
        ex("drain0", 0, 0, 1, 32'h0, 32'h100);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("drain1", 1, 32'h10, 1, 32'h4, 32'h101);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("drain2", 0, 0, 1, 32'h8, 32'h102);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("drain3", 0, 0, 1, 32'hC, 32'h103);
        tick();
        set_in(1, 32'h200, 1, 0, 0);
        ex("drain4", 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("resume", 1, 32'h14, 1, 32'h10, 32'h200);
        tick();

        // Redirect while a request is outstanding
        do_reset();
        set_in(0, 0, 0, 0, 0);
        ex("rd c0", 1, 32'h0, 0, 0, 0);
        tick();
        set_in(1, 32'h55AA, 0, 0, 0);
        ex("rd c1", 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        ex("rd c2", 1, 32'h4, 1, 32'h0, 32'h55AA);
        tick();
        set_in(0, 0, 0, 0, 0);
        ex("rd c3", 0, 0, 1, 32'h0, 32'h55AA);
        tick();
        set_in(0, 0, 0, 1, 32'h104);
        ex("rd c4", 0, 0, 1, 32'h0, 32'h55AA);
        tick();
        set_in(1, 32'hDEAD, 0, 0, 0);
        ex("rd drop", 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("rd new req", 1, 32'h104, 0, 0, 0);
        tick();
        set_in(1, 32'h55, 1, 0, 0);
        ex("rd rsp", 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("rd deliver", 1, 32'h108, 1, 32'h104, 32'h55);
        tick();

        // Redirect in the same cycle as the response; low bits masked
        do_reset();
        set_in(0, 0, 1, 0, 0);
        ex("rc c0", 1, 32'h0, 0, 0, 0);
        tick();
        set_in(1, 32'h77, 1, 1, 32'h20B);
        ex("rc c1", 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("rc c2", 1, 32'h208, 0, 0, 0);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("rc c3", 0, 0, 0, 0, 0);
        tick();

        // Push+pop at count 2 and fetch address wrap
        do_reset();
        set_in(0, 0, 0, 1, 32'hFFFFFFF4);
        ex("wr c0", 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        ex("wr c1", 1, 32'hFFFFFFF4, 0, 0, 0);
        tick();
        set_in(1, 32'hA1, 0, 0, 0);
        ex("wr c2", 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        ex("wr c3", 1, 32'hFFFFFFF8, 1, 32'hFFFFFFF4, 32'hA1);
        tick();
        set_in(1, 32'hA2, 0, 0, 0);
        ex("wr c4", 0, 0, 1, 32'hFFFFFFF4, 32'hA1);
        tick();
        set_in(0, 0, 0, 0, 0);
        ex("wr c5", 1, 32'hFFFFFFFC, 1, 32'hFFFFFFF4, 32'hA1);
        tick();
        set_in(1, 32'hA3, 1, 0, 0);
        ex("wr pushpop", 0, 0, 1, 32'hFFFFFFF4, 32'hA1);
        tick();
        set_in(0, 0, 0, 0, 0);
        ex("wr wrap", 1, 32'h0, 1, 32'hFFFFFFF8, 32'hA2);
        tick();
        set_in(1, 32'hA4, 0, 0, 0);
        ex("wr c8", 0, 0, 1, 32'hFFFFFFF8, 32'hA2);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("wr c9", 1, 32'h4, 1, 32'hFFFFFFF8, 32'hA2);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("wr c10", 0, 0, 1, 32'hFFFFFFFC, 32'hA3);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("wr c11", 0, 0, 1, 32'h0, 32'hA4);
        tick();
        set_in(0, 0, 1, 0, 0);
        ex("wr empty", 0, 0, 0, 0, 0);
        tick();

        // Reset mid-operation with 3 entries buffered and a request in flight
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 0, 0);
            ex($sformatf("mr%0d req", k), 1, 32'(4 * k), k != 0,
               32'h0, 32'hC0);
            tick();
            set_in(1, 32'(32'hC0 + k), 0, 0, 0);
            ex($sformatf("mr%0d rsp", k), 0, 0, k != 0, 32'h0, 32'hC0);
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        ex("mr wait", 1, 32'hC, 1, 32'h0, 32'hC0);
        tick();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        chk("mr rst imem_req", 32'(bus.imem_req), 32'd0);
        chk("mr rst if_valid", 32'(bus.if_valid), 32'd0);
        chk("mr rst imem_addr", bus.imem_addr, 32'd0);
        chk("mr rst if_instr", bus.if_instr, 32'd0);
        tick();
        rst = 1'b0;
        set_in(1, 32'hBAD, 0, 0, 0);
        ex("mr stray", 1, 32'h0, 0, 0, 0);
        tick();
        set_in(1, 32'h11, 0, 0, 0);
        ex("mr rsp", 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        ex("mr deliver", 1, 32'h4, 1, 32'h0, 32'h11);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end that owns the fetch address and pulls instructions out of a variable-latency instruction memory. It issues sequential word requests, buffers returned {pc, instruction} pairs in a small FIFO, and presents them to decode with a valid/ready handshake. Control-flow changes from execute arrive as a redirect, which flushes all in-flight and buffered work.

## Interface
- WIDTH, 32, address and instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2

- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- redirect  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  WIDTH  new fetch address; bits [1:0] ignored (treated as 0)
- imem_req  output  1  one-cycle request strobe
- imem_addr  output  WIDTH  request word address, valid when imem_req=1
- imem_rvalid  input  1  response strobe, one cycle
- imem_rdata  input  WIDTH  response instruction, valid with imem_rvalid
- if_valid  output  1  head entry available
- if_instr  output  WIDTH  head instruction
- if_pc  output  WIDTH  address of head instruction
- if_ready  input  1  decode accepts head

## Operation
- State machine: IDLE (nothing outstanding), WAIT (one request outstanding, response kept), DROP (one request outstanding, response discarded). At most one outstanding request.
- Issue: imem_req = (state==IDLE) && !redirect && count<DEPTH && !rst; imem_addr = fetch_pc. On issue: fetch_pc <= fetch_pc+4 (wraps modulo 2^WIDTH), req_pc <= fetch_pc, state → WAIT.
- WAIT + imem_rvalid (no redirect): push {req_pc, imem_rdata}, state → IDLE.
- DROP + imem_rvalid: no push, state → IDLE.
- imem_rvalid in IDLE: ignored, no push.
- Pop: when if_valid && if_ready && !redirect; head advances.
- if_valid = (count!=0); if_instr/if_pc = head entry (combinational from FIFO).
- Push and pop same cycle: both happen, count unchanged. Overflow impossible: issue requires count<DEPTH and count never grows without a prior issue.
- Redirect (highest priority) at the edge: fetch_pc <= {redirect_pc[WIDTH-1:2],2'b00}; FIFO emptied (count 0, pointers 0); no issue, no pop, no push that cycle. State: WAIT without rvalid → DROP; WAIT with rvalid → IDLE (response discarded); DROP without rvalid → DROP; DROP with rvalid → IDLE; IDLE → IDLE.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

## Timing
- Reset values: state IDLE, fetch_pc 0, req_pc 0, count 0, FIFO storage 0; imem_req 0 while rst high, imem_addr 0; if_valid 0, if_instr 0, if_pc 0.
- First request in the first cycle after rst deasserts, imem_addr=0.
- Memory may assert imem_rvalid no earlier than the cycle after imem_req; any later latency accepted.
- Response pushed at the rvalid edge; if_valid high in the next cycle.
- Zero-wait memory (rvalid one cycle after req): one request every 2 cycles; req cycle n, rvalid n+1, next req n+2.
- After redirect at edge n: earliest new request cycle n+1 if state is IDLE, else the cycle after the flushed response returns.
- Reset mid-operation: all state returns to reset values immediately; a response arriving after reset with state IDLE is ignored.

## Test plan
- Reset release, if_ready=1, memory latency 1: imem_addr sequence 0,4,8,12 on cycles 0,2,4,6; if_pc 0,4,8 with if_instr equal to returned data, one per 2 cycles.
- if_ready=0, DEPTH=4: exactly 4 requests issued (0..12), if_valid stays 1, imem_req stays 0; raise if_ready → pops 0,4,8,12 then fetch resumes at 16.
- Redirect to 0x104 while WAIT with latency 3: outstanding response dropped, FIFO empty (if_valid 0), next imem_addr = 0x104, first delivered if_pc = 0x104.
- Redirect coincident with imem_rvalid: data not pushed, state IDLE, next cycle imem_req=1 with imem_addr = redirect_pc & ~3.
- Simultaneous push and pop at count=2: count stays 2, order preserved; fetch_pc at 0xFFFFFFFC issues then wraps to 0.
- Assert rst during WAIT with FIFO holding 3 entries: if_valid 0 and imem_req 0 immediately; after release, first imem_addr=0, stray rvalid ignored.
